// File: rtl/trng_arbiter.sv
// trng_arbiter: shares one TRNG bit source between two requesters and
// delivers WORD_W-bit random words, one requester at a time.
//
// Flow: IDLE -> WARM (discard WARMUP valid bits) -> COLLECT (shift in
// WORD_W valid bits for the round-robin owner) -> DELIVER (one-cycle grant).
// Back-to-back words go DELIVER -> COLLECT without a new warm-up.
//
// Parameters:
//   WORD_W  width of each delivered word (>= 2)
//   WARMUP  valid TRNG bits discarded after enable rises (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req[1:0]     level requests, held until granted
//   gnt[1:0]     one-hot, one-cycle grant pulse marking word delivery
//   rdata        random word, valid only while gnt != 0 (0 otherwise)
//   trng_enable  TRNG enable
//   trng_bit     TRNG random bit, sampled only when trng_valid is high
//   trng_valid   TRNG bit qualifier
//   busy         high in every state except IDLE
//   health_fail  (only with TRNG_ARBITER_HEALTH_EN) sticky repetition-count
//                failure flag
//
// Optional feature macro: TRNG_ARBITER_HEALTH_EN. When defined, 8 identical
// consecutive valid bits in COLLECT set health_fail, discard the word and
// return to WARM; from then on the block parks in IDLE with the TRNG
// disabled until reset.
module trng_arbiter #(
  parameter int WORD_W = 16,
  parameter int WARMUP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic [WORD_W-1:0] rdata,
  output logic              trng_enable,
  input  logic              trng_bit,
  input  logic              trng_valid,
  output logic              busy
`ifdef TRNG_ARBITER_HEALTH_EN
  ,
  output logic              health_fail
`endif
);

  // Counters are sized to hold their terminal value without wrapping.
  localparam int BC_W = $clog2(WORD_W + 1);
  localparam int WC_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    COLLECT,
    DELIVER
  } state_t;

  state_t            state, state_n;
  logic              owner, owner_n;
  logic              last, last_n;
  logic [WC_W-1:0]   warm_cnt, warm_n;
  logic [BC_W-1:0]   bit_cnt, bit_n;
  logic [WORD_W-1:0] shreg, shreg_n;

`ifdef TRNG_ARBITER_HEALTH_EN
  logic [3:0] run_cnt, run_n;
  logic       prev_bit, prev_n;
  logic       hfail, hfail_n;

  assign health_fail = hfail;
`endif

  // Round-robin pick: on a tie the requester not served last wins.
  function automatic logic arb(input logic [1:0] r, input logic l);
    return (r == 2'b11) ? ~l : r[1];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef TRNG_ARBITER_HEALTH_EN
      run_cnt  <= '0;
      prev_bit <= 1'b0;
      hfail    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      warm_cnt <= warm_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
`ifdef TRNG_ARBITER_HEALTH_EN
      run_cnt  <= run_n;
      prev_bit <= prev_n;
      hfail    <= hfail_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    last_n      = last;
    warm_n      = warm_cnt;
    bit_n       = bit_cnt;
    shreg_n     = shreg;
    gnt         = '0;
    rdata       = '0;
    trng_enable = 1'b0;
    busy        = (state != IDLE);
`ifdef TRNG_ARBITER_HEALTH_EN
    // Repetition runs are only tracked inside one COLLECT stretch.
    run_n   = (state == COLLECT) ? run_cnt : '0;
    prev_n  = prev_bit;
    hfail_n = hfail;
`endif

    case (state)
      IDLE: begin
        warm_n = '0;
        bit_n  = '0;
        if (|req) state_n = WARM;
      end

      WARM: begin
        trng_enable = 1'b1;
        if (req == 2'b00) begin
          state_n = IDLE;
        end else if (trng_valid) begin
          warm_n = warm_cnt + WC_W'(1);
          if (warm_n == WC_W'(WARMUP)) begin
            state_n = COLLECT;
            owner_n = arb(req, last);
            bit_n   = '0;
            shreg_n = '0;
          end
        end
      end

      COLLECT: begin
        trng_enable = 1'b1;
        if (!req[owner]) begin
          // Owner withdrew: drop the partial word and re-arbitrate.
          bit_n   = '0;
          shreg_n = '0;
`ifdef TRNG_ARBITER_HEALTH_EN
          run_n   = '0;
`endif
          if (|req) owner_n = arb(req, last);
          else      state_n = IDLE;
        end else if (trng_valid) begin
          shreg_n = {shreg[WORD_W-2:0], trng_bit};
          bit_n   = bit_cnt + BC_W'(1);
`ifdef TRNG_ARBITER_HEALTH_EN
          run_n  = (run_cnt != 4'd0 && trng_bit == prev_bit) ? run_cnt + 4'd1 : 4'd1;
          prev_n = trng_bit;
          if (run_n == 4'd8) begin
            hfail_n = 1'b1;
            state_n = WARM;
            warm_n  = '0;
            bit_n   = '0;
            run_n   = '0;
            shreg_n = '0;
          end else if (bit_n == BC_W'(WORD_W)) begin
            state_n = DELIVER;
          end
`else
          if (bit_n == BC_W'(WORD_W)) state_n = DELIVER;
`endif
        end
      end

      DELIVER: begin
        trng_enable = 1'b1;
        gnt[owner]  = 1'b1;
        rdata       = shreg;
        last_n      = owner;
        bit_n       = '0;
        // The just-served owner counts as last served for this pick.
        if (|req) begin
          state_n = COLLECT;
          owner_n = arb(req, owner);
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

`ifdef TRNG_ARBITER_HEALTH_EN
    // A failed health test parks the block with the TRNG off until reset.
    if (hfail) begin
      state_n     = IDLE;
      trng_enable = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_trng_arbiter.sv
// Self-checking bench for trng_arbiter. The reference model works at the
// transaction level: a word is the last WORD_W valid bits fed after the
// warm-up, grants follow round-robin order, and grant timing is derived
// from counting valid bits and the fixed IDLE/DELIVER overhead cycles.
module tb_trng_arbiter;

  localparam int W  = 16;
  localparam int WU = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [1:0]   gnt;
  logic [W-1:0] rdata;
  logic         trng_enable;
  logic         trng_bit = 1'b0;
  logic         trng_valid = 1'b0;
  logic         busy;
`ifdef TRNG_ARBITER_HEALTH_EN
  logic         health_fail;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic rr_last  = 1'b1;
  int   run_len  = 0;
  logic run_bit  = 1'b0;

  trng_arbiter #(.WORD_W(W), .WARMUP(WU)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .rdata       (rdata),
    .trng_enable (trng_enable),
    .trng_bit    (trng_bit),
    .trng_valid  (trng_valid),
    .busy        (busy)
`ifdef TRNG_ARBITER_HEALTH_EN
    ,
    .health_fail (health_fail)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    trng_valid = v;
    trng_bit   = b;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic note_bit(input logic b);
    if (run_len > 0 && b == run_bit) run_len++;
    else run_len = 1;
    run_bit = b;
  endtask

  // Random bits with runs capped at 7 so no word trips the health test.
  task automatic gen_bit(output logic b);
    b = 1'($urandom);
    if (run_len >= 7) b = ~run_bit;
  endtask

  function automatic logic pick(input logic [1:0] r);
    return (r == 2'b11) ? ~rr_last : r[1];
  endfunction

  function automatic logic [1:0] onehot(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  // Feed nbits valid bits, one every 'period' cycles; garbage bits on
  // invalid cycles. Returns the last W valid bits, earliest in the MSB.
  task automatic feed(input int nbits, input int period, input logic use_fixed,
                      input logic [W-1:0] fixed, output logic [W-1:0] word);
    int got = 0;
    int ph  = 0;
    word = '0;
    while (got < nbits) begin
      logic v;
      logic b;
      check("no_early_gnt", 32'(gnt), 32'(0));
      ph++;
      v = ((ph % period) == 0);
      if (v) begin
        if (use_fixed && got >= nbits - W) b = fixed[W - 1 - (got - (nbits - W))];
        else gen_bit(b);
        note_bit(b);
        word = {word[W-2:0], b};
        got++;
      end else begin
        b = 1'($urandom);
      end
      step(v, b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_enable", 32'(trng_enable), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rr_last = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    logic         eo;
    logic [1:0]   m;
    int           t0;
    int           tg;
    int           p;

    // Reset state
    do_reset();

    // Valid bits with no request are ignored
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom));
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_enable", 32'(trng_enable), 32'(0));

    // Single request, fixed word, exact latency
    req = 2'b01;
    t0 = cyc;
    step(1'b1, 1'($urandom));
    check("warm_busy", 32'(busy), 32'(1));
    check("warm_enable", 32'(trng_enable), 32'(1));
    feed(WU + W, 1, 1'b1, 16'b1010_1100_0011_0101, w);
    check("single_gnt", 32'(gnt), 32'(2'b01));
    check("single_rdata", 32'(rdata), 32'(16'hAC35));
    check("single_latency", 32'(cyc - t0 + 1), 32'(WU + W + 2));
    rr_last = 1'b0;
    req = 2'b00;
    step(1'b0, 1'b0);
    check("after_single_busy", 32'(busy), 32'(0));
    check("after_single_gnt", 32'(gnt), 32'(0));
    check("after_single_rdata", 32'(rdata), 32'(0));

    // Contention from fresh reset: alternating grants, 17-cycle spacing
    do_reset();
    req = 2'b11;
    step(1'b1, 1'($urandom));
    eo = pick(req);
    feed(WU + W, 1, 1'b0, '0, w);
    check("cont_gnt0", 32'(gnt), 32'(onehot(eo)));
    check("cont_rdata0", 32'(rdata), 32'(w));
    rr_last = eo;
    tg = cyc;
    for (int k = 1; k < 4; k++) begin
      step(1'b1, 1'($urandom));
      eo = pick(req);
      feed(W, 1, 1'b0, '0, w);
      check("cont_gnt", 32'(gnt), 32'(onehot(eo)));
      check("cont_rdata", 32'(rdata), 32'(w));
      check("cont_gap", 32'(cyc - tg), 32'(W + 1));
      rr_last = eo;
      tg = cyc;
    end

    // Abort: owner 0 withdraws after 5 bits, requester 1 gets a fresh word
    step(1'b1, 1'($urandom));
    feed(5, 1, 1'b0, '0, w);
    req = 2'b10;
    step(1'b1, 1'($urandom));
    feed(W, 1, 1'b0, '0, w);
    check("abort_gnt", 32'(gnt), 32'(2'b10));
    check("abort_rdata", 32'(rdata), 32'(w));
    rr_last = 1'b1;
    req = 2'b00;
    step(1'b0, 1'b0);
    check("abort_idle", 32'(busy), 32'(0));

    // Sparse valid: every 3rd cycle
    req = 2'b10;
    t0 = cyc;
    step(1'b1, 1'($urandom));
    feed(WU + W, 3, 1'b0, '0, w);
    check("sparse_gnt", 32'(gnt), 32'(2'b10));
    check("sparse_rdata", 32'(rdata), 32'(w));
    check("sparse_latency", 32'(cyc - t0 + 1), 32'(2 + 3 * (WU + W)));
    rr_last = 1'b1;
    req = 2'b00;
    step(1'b0, 1'b0);

    // Random requesters and valid spacing
    for (int k = 0; k < 4; k++) begin
      m = 2'($urandom_range(1, 3));
      p = $urandom_range(1, 4);
      req = m;
      t0 = cyc;
      step(1'b1, 1'($urandom));
      eo = pick(m);
      feed(WU + W, p, 1'b0, '0, w);
      check("rand_gnt", 32'(gnt), 32'(onehot(eo)));
      check("rand_rdata", 32'(rdata), 32'(w));
      check("rand_latency", 32'(cyc - t0 + 1), 32'(2 + p * (WU + W)));
      rr_last = eo;
      req = 2'b00;
      step(1'b0, 1'b0);
      check("rand_idle", 32'(busy), 32'(0));
    end

    // Request dropped during warm-up returns to IDLE
    req = 2'b01;
    step(1'b1, 1'($urandom));
    feed(3, 1, 1'b0, '0, w);
    req = 2'b00;
    step(1'b1, 1'($urandom));
    check("warmdrop_busy", 32'(busy), 32'(0));
    check("warmdrop_enable", 32'(trng_enable), 32'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom));
    check("warmdrop_stay", 32'(busy), 32'(0));

    // Reset asserted mid-COLLECT
    req = 2'b01;
    step(1'b1, 1'($urandom));
    feed(WU + 10, 1, 1'b0, '0, w);
    rst = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'(0));
    check("midrst_enable", 32'(trng_enable), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_rdata", 32'(rdata), 32'(0));
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rr_last = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'($urandom));
      check("postrst_no_gnt", 32'(gnt), 32'(0));
    end
    check("postrst_busy", 32'(busy), 32'(0));

`ifdef TRNG_ARBITER_HEALTH_EN
    // Eight identical bits in COLLECT trip the health test
    req = 2'b01;
    step(1'b1, 1'($urandom));
    feed(WU, 1, 1'b0, '0, w);
    feed(8, 1, 1'b1, 16'h00FF, w);
    check("hf_set", 32'(health_fail), 32'(1));
    check("hf_gnt", 32'(gnt), 32'(0));
    check("hf_enable", 32'(trng_enable), 32'(0));
    step(1'b1, 1'($urandom));
    check("hf_idle", 32'(busy), 32'(0));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom));
      check("hf_no_gnt", 32'(gnt), 32'(0));
    end
    check("hf_enable_off", 32'(trng_enable), 32'(0));
    check("hf_sticky", 32'(health_fail), 32'(1));
    req = 2'b00;
    do_reset();
    check("hf_cleared", 32'(health_fail), 32'(0));
`else
    // Long runs of identical bits are delivered unchanged
    req = 2'b01;
    step(1'b1, 1'($urandom));
    feed(WU + W, 1, 1'b1, 16'hFF00, w);
    check("run_gnt", 32'(gnt), 32'(2'b01));
    check("run_rdata", 32'(rdata), 32'(16'hFF00));
    req = 2'b00;
    step(1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
